// File: rtl/dma_arb_pkg.sv
// Shared encodings for the CPU/DMA bus arbiter, the memory port mux and the DMA controller.
// Holds the state codes, the bus-owner select values and a counter width helper.
package dma_arb_pkg;

    localparam logic [2:0] ST_CPU_OWN    = 3'd0;
    localparam logic [2:0] ST_GRANT_WAIT = 3'd1;
    localparam logic [2:0] ST_DMA_OWN    = 3'd2;
    localparam logic [2:0] ST_RELEASE    = 3'd3;
    localparam logic [2:0] ST_CPU_HOLD   = 3'd4;

    typedef enum logic [2:0] {
        CPU_OWN    = ST_CPU_OWN,
        GRANT_WAIT = ST_GRANT_WAIT,
        DMA_OWN    = ST_DMA_OWN,
        RELEASE    = ST_RELEASE,
        CPU_HOLD   = ST_CPU_HOLD
    } arb_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/arb_hold_counter.sv
// Loadable down-counter that stops at zero; times the guaranteed CPU window.
// Load takes priority over decrement.
module arb_hold_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/dma_bus_arbiter.sv
// Memory bus arbiter between the CPU memory stage and the DMA engine.
// Grants only at CPU access boundaries and forces a DMA yield after a bounded burst.
//
// state      | meaning
// CPU_OWN    | CPU owns the bus, BR evaluated
// GRANT_WAIT | BR pending, waiting for the CPU access in flight to finish
// DMA_OWN    | DMA owns the bus, BG asserted
// RELEASE    | one-cycle turnaround after BR drops
// CPU_HOLD   | guaranteed CPU window after a yield, BR ignored
module dma_bus_arbiter
    import dma_arb_pkg::*;
#(
    parameter int MAX_BURST_WORDS = 12,
    parameter int CPU_MIN_CYCLES  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_mem_req,
    input  logic cpu_mem_busy,
    input  logic BR,
    input  logic dma_word_done,
    output logic BG,
    output logic dma_yield,
    output logic bus_owner,
    output logic cpu_stall
);

    localparam int WORD_W = cnt_width(MAX_BURST_WORDS);
    localparam int HOLD_W = cnt_width(CPU_MIN_CYCLES - 1);
    localparam logic [WORD_W-1:0] WORD_MAX  = WORD_W'(MAX_BURST_WORDS);
    localparam logic [HOLD_W-1:0] HOLD_LOAD =
        (CPU_MIN_CYCLES > 0) ? HOLD_W'(CPU_MIN_CYCLES - 1) : '0;
    localparam logic YIELD_EN = (MAX_BURST_WORDS > 0);
    localparam logic HOLD_EN  = (CPU_MIN_CYCLES > 0);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic              r_bg;
    logic              r_owner;
    logic              r_yield;
    logic              r_yielded;
    logic [WORD_W-1:0] r_word_cnt;
    logic              w_enter_dma;
    logic              w_yield_set;
    logic              w_hold_load;
    logic              w_hold_dec;
    logic              w_hold_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CPU_OWN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            CPU_OWN: begin
                if (BR) begin
                    w_next = cpu_mem_busy ? GRANT_WAIT : DMA_OWN;
                end
            end
            GRANT_WAIT: begin
                if (!BR) begin
                    w_next = CPU_OWN;
                end else if (!cpu_mem_busy) begin
                    w_next = DMA_OWN;
                end
            end
            DMA_OWN: begin
                if (!BR) begin
                    w_next = RELEASE;
                end
            end
            RELEASE: begin
                w_next = (r_yielded && HOLD_EN) ? CPU_HOLD : CPU_OWN;
            end
            CPU_HOLD: begin
                if (w_hold_zero) begin
                    w_next = CPU_OWN;
                end
            end
            default: begin
                w_next = CPU_OWN;
            end
        endcase
    end

    assign w_enter_dma = (r_state != DMA_OWN) && (w_next == DMA_OWN);
    assign w_yield_set = YIELD_EN && (r_state == DMA_OWN) &&
                         (r_word_cnt >= WORD_MAX) && cpu_mem_req;

    // r_yielded remembers that this grant was asked to yield, for the RELEASE decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bg       <= 1'b0;
            r_owner    <= OWNER_CPU;
            r_yield    <= 1'b0;
            r_yielded  <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_bg    <= (w_next == DMA_OWN);
            r_owner <= (w_next == DMA_OWN) ? OWNER_DMA : OWNER_CPU;
            r_yield <= (w_next == DMA_OWN) && (r_yield || w_yield_set);
            if (w_enter_dma) begin
                r_yielded <= 1'b0;
            end else if (r_yield) begin
                r_yielded <= 1'b1;
            end
            if (w_enter_dma) begin
                r_word_cnt <= '0;
            end else if ((r_state == DMA_OWN) && dma_word_done &&
                         (r_word_cnt != WORD_MAX)) begin
                r_word_cnt <= r_word_cnt + WORD_W'(1);
            end
        end
    end

    assign w_hold_load = (r_state == RELEASE) && (w_next == CPU_HOLD);
    assign w_hold_dec  = (r_state == CPU_HOLD);

    arb_hold_counter #(
        .WIDTH(HOLD_W)
    ) u_hold_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_hold_load),
        .i_load_val (HOLD_LOAD),
        .i_dec      (w_hold_dec),
        .o_zero     (w_hold_zero)
    );

    // A busy CPU access is never frozen; the DMA wins a same-cycle tie with a new access.
    assign cpu_stall = cpu_mem_req && !cpu_mem_busy &&
                       ((r_state == DMA_OWN) || (r_state == RELEASE) ||
                        (r_state == GRANT_WAIT) ||
                        ((r_state == CPU_OWN) && BR));

    assign BG        = r_bg;
    assign bus_owner = r_owner;
    assign dma_yield = r_yield;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Scoreboard bench for dma_bus_arbiter: the driver queues expected outputs per cycle,
// the monitor pops and compares at the falling edge.
module tb_dma_bus_arbiter;

    logic clk;
    logic reset;
    logic cpu_mem_req;
    logic cpu_mem_busy;
    logic BR;
    logic dma_word_done;
    logic bg_a, yield_a, owner_a, stall_a;
    logic bg_b, yield_b, owner_b, stall_b;

    typedef struct {
        logic [3:0] exp;
        logic [3:0] mask;
        logic       sel;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    dma_bus_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_mem_req   (cpu_mem_req),
        .cpu_mem_busy  (cpu_mem_busy),
        .BR            (BR),
        .dma_word_done (dma_word_done),
        .BG            (bg_a),
        .dma_yield     (yield_a),
        .bus_owner     (owner_a),
        .cpu_stall     (stall_a)
    );

    dma_bus_arbiter #(
        .MAX_BURST_WORDS(0),
        .CPU_MIN_CYCLES (4)
    ) dut_noyield (
        .clk           (clk),
        .reset         (reset),
        .cpu_mem_req   (cpu_mem_req),
        .cpu_mem_busy  (cpu_mem_busy),
        .BR            (BR),
        .dma_word_done (dma_word_done),
        .BG            (bg_b),
        .dma_yield     (yield_b),
        .bus_owner     (owner_b),
        .cpu_stall     (stall_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // iv = {reset, BR, dma_word_done, cpu_mem_req, cpu_mem_busy}
    // ev = {BG, bus_owner, dma_yield, cpu_stall}; mv selects which bits are checked
    task automatic cyc(input logic [4:0] iv, input logic [3:0] ev, input logic [3:0] mv,
                       input logic sel, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        {reset, BR, dma_word_done, cpu_mem_req, cpu_mem_busy} = iv;
        e.exp  = ev;
        e.mask = mv;
        e.sel  = sel;
        e.tag  = tag;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(5'b00000, 4'b0000, 4'b0000, 1'b0, "idle");
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] act;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.mask != 4'b0000) begin
                act = e.sel ? {bg_b, owner_b, yield_b, stall_b}
                            : {bg_a, owner_a, yield_a, stall_a};
                n_compared++;
                if ((act & e.mask) != (e.exp & e.mask)) begin
                    n_mismatched++;
                    $display("FAIL %s: {BG,owner,yield,stall} got %b want %b (mask %b) t=%0t",
                             e.tag, act, e.exp, e.mask, $time);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; BR = 1'b0; dma_word_done = 1'b0;
        cpu_mem_req = 1'b0; cpu_mem_busy = 1'b0;

        // reset state
        cyc(5'b10000, 4'b0000, 4'b1111, 1'b0, "reset_state");
        cyc(5'b10000, 4'b0000, 4'b1111, 1'b1, "reset_state_noyield");
        cyc(5'b00000, 4'b0000, 4'b1111, 1'b0, "reset_release");

        // CPU idle grant, 1-cycle latency, release
        cyc(5'b01000, 4'b0000, 4'b1111, 1'b0, "idle_grant_c0");
        for (int i = 1; i <= 19; i++) cyc(5'b01000, 4'b1100, 4'b1111, 1'b0, "idle_grant_on");
        cyc(5'b00000, 4'b1100, 4'b1111, 1'b0, "idle_br_fall");
        cyc(5'b00010, 4'b0001, 4'b1111, 1'b0, "idle_release");
        cyc(5'b00010, 4'b0000, 4'b1111, 1'b0, "idle_back_cpu");
        idle(3);

        // busy CPU access defers the grant
        cyc(5'b00011, 4'b0000, 4'b1111, 1'b0, "busy_c0");
        for (int i = 1; i <= 3; i++) cyc(5'b01011, 4'b0000, 4'b1111, 1'b0, "busy_wait");
        cyc(5'b01010, 4'b0001, 4'b1111, 1'b0, "busy_clear_stall");
        cyc(5'b01010, 4'b1101, 4'b1111, 1'b0, "busy_grant");
        cyc(5'b00000, 4'b1100, 4'b1111, 1'b0, "busy_br_fall");
        cyc(5'b00000, 4'b0000, 4'b1111, 1'b0, "busy_release");
        cyc(5'b00000, 4'b0000, 4'b1111, 1'b0, "busy_cpu");
        idle(3);

        // burst of 12 words with CPU waiting -> yield, hold window, re-grant
        cyc(5'b01010, 4'b0001, 4'b1111, 1'b0, "yield_tie_stall");
        for (int i = 1; i <= 12; i++) cyc(5'b01110, 4'b1101, 4'b1111, 1'b0, "yield_burst");
        cyc(5'b01010, 4'b1101, 4'b1111, 1'b0, "yield_cnt12");
        cyc(5'b01010, 4'b1111, 4'b1111, 1'b0, "yield_set");
        cyc(5'b01000, 4'b1110, 4'b1111, 1'b0, "yield_req_drop");
        cyc(5'b00000, 4'b1110, 4'b1111, 1'b0, "yield_br_fall");
        cyc(5'b01010, 4'b0001, 4'b1101, 1'b0, "yield_release");
        for (int i = 0; i < 4; i++) cyc(5'b01010, 4'b0000, 4'b1111, 1'b0, "yield_cpu_hold");
        cyc(5'b01010, 4'b0001, 4'b1111, 1'b0, "yield_hold_exit");
        cyc(5'b01010, 4'b1101, 4'b1111, 1'b0, "yield_regrant");
        cyc(5'b00000, 4'b1100, 4'b1111, 1'b0, "regrant_br_fall");
        cyc(5'b00000, 4'b0000, 4'b1111, 1'b0, "regrant_release");
        cyc(5'b01000, 4'b0000, 4'b1111, 1'b0, "noyield_to_cpu_own");
        cyc(5'b01000, 4'b1100, 4'b1111, 1'b0, "noyield_fast_grant");
        cyc(5'b00000, 4'b1100, 4'b1111, 1'b0, "fast_br_fall");
        cyc(5'b00000, 4'b0000, 4'b1111, 1'b0, "fast_release");
        idle(10);

        // MAX_BURST_WORDS=0: 30 words, no yield, CPU stalled throughout
        cyc(5'b01010, 4'b0001, 4'b1111, 1'b1, "max0_c0");
        for (int i = 1; i <= 30; i++) cyc(5'b01110, 4'b1101, 4'b1111, 1'b1, "max0_burst");
        cyc(5'b01010, 4'b1101, 4'b1111, 1'b1, "max0_after");
        cyc(5'b01010, 4'b1101, 4'b1111, 1'b1, "max0_after");
        cyc(5'b00010, 4'b1101, 4'b1111, 1'b1, "max0_br_fall");
        cyc(5'b00010, 4'b0001, 4'b1111, 1'b1, "max0_release");
        cyc(5'b00010, 4'b0000, 4'b1111, 1'b1, "max0_cpu_own");
        idle(10);

        // async reset mid-grant with word_cnt=5
        cyc(5'b01000, 4'b0000, 4'b0000, 1'b0, "rst_mid_c0");
        for (int i = 1; i <= 5; i++) cyc(5'b01100, 4'b1100, 4'b1111, 1'b0, "rst_mid_words");
        cyc(5'b01000, 4'b1100, 4'b1111, 1'b0, "rst_mid_cnt5");
        cyc(5'b11000, 4'b0000, 4'b1111, 1'b0, "rst_mid_async");
        cyc(5'b01000, 4'b0000, 4'b1111, 1'b0, "rst_mid_released");
        for (int i = 0; i < 7; i++) cyc(5'b01110, 4'b1101, 4'b1111, 1'b0, "rst_regrant_words");
        cyc(5'b01010, 4'b1101, 4'b1111, 1'b0, "rst_cnt_restart");
        cyc(5'b01010, 4'b1101, 4'b1111, 1'b0, "rst_cnt_restart");
        cyc(5'b00000, 4'b1100, 4'b1111, 1'b0, "rst_br_fall");
        cyc(5'b00000, 4'b0000, 4'b1111, 1'b0, "rst_release");
        idle(3);

        // BR withdrawn while waiting on a busy CPU access
        cyc(5'b01001, 4'b0000, 4'b1111, 1'b0, "gw_c0");
        cyc(5'b01011, 4'b0000, 4'b1111, 1'b0, "gw_busy_no_stall");
        cyc(5'b00001, 4'b0000, 4'b1111, 1'b0, "gw_br_fall");
        cyc(5'b00010, 4'b0000, 4'b1111, 1'b0, "gw_cpu_access");
        cyc(5'b00010, 4'b0000, 4'b1111, 1'b0, "gw_no_grant");
        cyc(5'b00000, 4'b0000, 4'b1111, 1'b0, "gw_no_grant");

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Owns the memory bus between the CPU and the DMA engine.
- Answers the DMA engine's BR with BG only at CPU access boundaries, and stalls CPU memory requests while the DMA owns the bus.
- Enforces CPU fairness: after a bounded burst, it asks the DMA engine to yield at a word boundary, then guarantees the CPU a minimum bus window before re-granting.
- Sits between the CPU's memory stage, the DMA controller and the memory port mux, whose select it drives.

Parameters:
- MAX_BURST_WORDS, 12, DMA words allowed per grant before a yield is requested while the CPU is waiting; 0 disables yield.
- CPU_MIN_CYCLES, 4, guaranteed CPU-ownership cycles after a yield-induced release; 0 means straight back to CPU_OWN.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_mem_req  in  1  CPU wants a memory access this cycle
- cpu_mem_busy  in  1  CPU multi-cycle access in flight; must not be interrupted
- BR  in  1  bus request from DMA controller, level, held for the whole transfer
- dma_word_done  in  1  1-cycle pulse: DMA finished one word, bus at a word boundary
- BG  out  1  bus grant to DMA controller, registered
- dma_yield  out  1  request that the DMA drop BR at its next word boundary, registered
- bus_owner  out  1  memory mux select: 0 = CPU, 1 = DMA, registered
- cpu_stall  out  1  combinational; freezes the CPU memory stage

Behaviour:
- Reset (async, any state): state CPU_OWN; BG=0, dma_yield=0, bus_owner=0, word_cnt=0, hold_cnt=0. A reset mid-grant drops BG immediately.
- States:
  - CPU_OWN: if BR and !cpu_mem_busy, go to DMA_OWN. If BR and cpu_mem_busy, go to GRANT_WAIT. Otherwise stay.
  - GRANT_WAIT: if BR falls, go to CPU_OWN. Else, once !cpu_mem_busy, go to DMA_OWN.
  - DMA_OWN: BG=1, bus_owner=1. The grant is seen the cycle after entry, so latency from BR to BG is 1 cycle when the CPU is idle. If BR falls, go to RELEASE.
  - RELEASE: 1-cycle turnaround. BG=0, bus_owner=0. Go to CPU_HOLD if dma_yield was asserted during this grant and CPU_MIN_CYCLES>0; otherwise go to CPU_OWN.
  - CPU_HOLD: BR is ignored. hold_cnt is loaded with CPU_MIN_CYCLES-1 on entry and decrements each cycle. When hold_cnt=0, go to CPU_OWN.
- word_cnt:
  - Cleared on entry to DMA_OWN; +1 on each dma_word_done while in DMA_OWN.
  - Saturates at MAX_BURST_WORDS; no wrap.
  - Width is clog2(MAX_BURST_WORDS+1), minimum 1.
- dma_yield:
  - Set on the clock after (state==DMA_OWN, MAX_BURST_WORDS>0, word_cnt>=MAX_BURST_WORDS, cpu_mem_req).
  - Held until state leaves DMA_OWN, and cleared in RELEASE.
  - If cpu_mem_req drops after yield is set, yield stays asserted; the grant still ends.
- cpu_stall = cpu_mem_req AND any of:
  - state is DMA_OWN or RELEASE;
  - state is GRANT_WAIT and !cpu_mem_busy;
  - state is CPU_OWN and BR and !cpu_mem_busy, i.e. the DMA wins a tie with a new CPU access.
  - Never asserted in CPU_HOLD or for an access with cpu_mem_busy=1.
- Simultaneous events:
  - BR falling in the same cycle as dma_word_done: count the word, then go to RELEASE.
  - BR rising in RELEASE: ignored, re-evaluated in CPU_OWN/CPU_HOLD.
  - dma_word_done outside DMA_OWN: ignored.
- BG never rises while cpu_mem_busy=1.
- BG and bus_owner=1 never overlap RELEASE or CPU_HOLD.

Decomposition:
- Shared package `dma_arb_pkg` holds the state encoding (CPU_OWN, GRANT_WAIT, DMA_OWN, RELEASE, CPU_HOLD as 3-bit localparams) and OWNER_CPU/OWNER_DMA constants. The memory mux and DMA controller reuse the same constants.
- One natural sub-module: `arb_hold_counter`, a loadable saturating down-counter with a zero flag, used for hold_cnt.
- word_cnt stays inline.

Test Plan:
- CPU idle, BR=1 at cycle 0 → BG=1 and bus_owner=1 at cycle 1; BR=0 at cycle 20 → BG=0 at cycle 21 (RELEASE), CPU_OWN at cycle 22; dma_yield stays 0.
- cpu_mem_busy=1 for cycles 0–3 with BR=1 from cycle 1 → BG stays 0 until cycle 4 low, BG=1 at cycle 5; cpu_stall=0 during cycles 0–3.
- Grant active, cpu_mem_req=1 held, 12 dma_word_done pulses → dma_yield=1 the cycle after word_cnt hits 12; cpu_stall=1 throughout. BR drop → RELEASE, then 4 CPU_HOLD cycles with cpu_stall=0 while BR=1 is ignored; BG re-asserted 1 cycle after CPU_HOLD exits.
- MAX_BURST_WORDS=0, 30 words with cpu_mem_req=1 → dma_yield never asserted; CPU stalled for the whole grant.
- Reset pulse mid-DMA_OWN (word_cnt=5) → BG, bus_owner and dma_yield go 0 asynchronously within the same cycle; after reset release with BR=1 and CPU idle, BG=1 one cycle later and word_cnt restarts at 0.
- BR falls in GRANT_WAIT before cpu_mem_busy clears → BG never rises; state returns to CPU_OWN, no stall on the next CPU access.
